// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter/mux.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: arb_state_t FSM encoding, NUM_REQ, SEL_W, CNT_W, idx_to_onehot().
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  // Hold counter width; covers MAX_HOLD-1 up to 14.
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req bit at or after ptr, modulo 4.
// Latency: purely combinational.
// Backpressure: none; output is a pure function of req and ptr.
// Ports: req[3:0] candidates, ptr[1:0] highest-priority slot,
//        vld = any candidate, idx = index of the winner (ptr when !vld).
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               vld,
  output logic [SEL_W-1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    vld = |req;
    idx = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// 4-requester round-robin arbiter driving a shared registered 4:1 data mux.
// Latency: req -> gnt/sel 1 cycle; gnt -> f/f_valid 1 further cycle.
// Backpressure: none; a requester holds req until served, owner capped at MAX_HOLD cycles when contended.
// Ports: clk, rst (sync, active-high), req[3:0], a0..a3[WIDTH-1:0] requester data,
//        gnt[3:0] one-hot/zero grant, sel[1:0] grant index, f/f_valid shared data, busy = in GRANT.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4   // legal 1..15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   a2,
  input  logic [WIDTH-1:0]   a3,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic [WIDTH-1:0]   f,
  output logic               f_valid,
  output logic               busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t         state_q, state_d;
  logic [3:0]         gnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pick_vld;
  logic [SEL_W-1:0]   pick_idx;
  logic               take_new;
  logic [WIDTH-1:0]   a_sel;

  // The current owner is masked out of the candidates. In IDLE gnt is zero,
  // and when the owner has dropped req its bit is already clear, so one
  // picker serves all three "choose a new owner" situations.
  rr_pick4 u_pick (
    .req (req & ~gnt),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt;
    sel_d    = sel;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    take_new = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) take_new = 1'b1;
      end
      GRANT: begin
        if (req[sel]) begin
          if (cnt_q < HOLD_LAST) begin
            cnt_d = cnt_q + 4'd1;
          end else if (pick_vld) begin
            take_new = 1'b1;
          end
          // else: uncontended owner keeps the grant, count stays saturated
        end else if (pick_vld) begin
          take_new = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (take_new) begin
      state_d = GRANT;
      gnt_d   = idx_to_onehot(pick_idx);
      sel_d   = pick_idx;
      ptr_d   = pick_idx + 2'd1;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    case (sel)
      2'd0:    a_sel = a0;
      2'd1:    a_sel = a1;
      2'd2:    a_sel = a2;
      default: a_sel = a3;
    endcase
  end

  // f only reloads while a grant is active, so it holds through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      f       <= '0;
      f_valid <= 1'b0;
    end else begin
      f_valid <= |gnt;
      if (|gnt) f <= a_sel;
    end
  end

  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int W  = 8;
  localparam int MH = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] a0, a1, a2, a3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] f;
  logic         f_valid;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a0      (a0),
    .a1      (a1),
    .a2      (a2),
    .a3      (a3),
    .gnt     (gnt),
    .sel     (sel),
    .f       (f),
    .f_valid (f_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (owner index, -1 = idle) ----------------
  int           m_owner = -1;
  int           m_sel   = 0;
  int           m_ptr   = 0;
  int           m_run   = 0;   // cycles the current owner has held so far, minus one
  logic [W-1:0] m_f     = '0;
  logic         m_fv    = 1'b0;

  function automatic logic [W-1:0] data_of(input int i);
    case (i)
      0:       return a0;
      1:       return a1;
      2:       return a2;
      default: return a3;
    endcase
  endfunction

  function automatic int rr_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_sel   = w;
    m_ptr   = (w + 1) % 4;
    m_run   = 0;
  endtask

  task automatic model_edge();
    int w;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_run = 0; m_f = '0; m_fv = 1'b0;
      return;
    end
    m_fv = (m_owner >= 0);
    if (m_owner >= 0) m_f = data_of(m_sel);
    if (m_owner < 0) begin
      w = rr_winner(req, m_ptr);
      if (w >= 0) model_grant(w);
    end else if (req[m_owner]) begin
      if (m_run + 1 < MH) begin
        m_run++;
      end else begin
        w = rr_winner(req & ~(4'b0001 << m_owner), m_ptr);
        if (w >= 0) model_grant(w);
      end
    end else begin
      w = rr_winner(req, m_ptr);
      if (w >= 0) model_grant(w);
      else begin m_owner = -1; m_run = 0; end
    end
  endtask

  function automatic logic [3:0] m_gnt();
    if (m_owner < 0) return 4'b0000;
    return 4'b0001 << m_owner;
  endfunction

  // Drive inputs, take one rising edge, advance the model, settle.
  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_vec++; if (sel !== 2'b00) begin n_err++; $display("FAIL reset_sel: got %b expected 00", sel); end
    n_vec++; if (f !== '0) begin n_err++; $display("FAIL reset_f: got %h expected 00", f); end
    n_vec++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL reset_fvalid: got %b expected 0", f_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    step(4'b0000, 1'b1);
    a0 = 8'h01; a1 = 8'hEE; a2 = 8'hEE; a3 = 8'hEE;
    step(4'b0001, 1'b0);
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    n_vec++; if (sel !== 2'b00) begin n_err++; $display("FAIL single_sel: got %b expected 00", sel); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
    n_vec++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL single_fvalid_early: got %b expected 0", f_valid); end
    step(4'b0001, 1'b0);
    n_vec++; if (f !== 8'h01) begin n_err++; $display("FAIL single_f: got %h expected 01", f); end
    n_vec++; if (f_valid !== 1'b1) begin n_err++; $display("FAIL single_fvalid: got %b expected 1", f_valid); end
  endtask

  task automatic test_all_req();
    int eo;
    step(4'b0000, 1'b1);
    a0 = 8'h10; a1 = 8'h11; a2 = 8'h12; a3 = 8'h13;
    for (int k = 0; k < 24; k++) begin
      step(4'b1111, 1'b0);
      eo = (k / MH) % 4;
      n_vec++; if (gnt !== (4'b0001 << eo)) begin n_err++; $display("FAIL rr_gnt cyc %0d: got %b expected owner %0d", k, gnt, eo); end
      n_vec++; if (sel !== 2'(eo)) begin n_err++; $display("FAIL rr_sel cyc %0d: got %0d expected %0d", k, sel, eo); end
      if (k >= 1) begin
        n_vec++;
        if (f !== 8'h10 + 8'(((k - 1) / MH) % 4) || f_valid !== 1'b1) begin
          n_err++; $display("FAIL rr_f cyc %0d: got %h/%b expected %h/1", k, f, f_valid, 8'h10 + 8'(((k - 1) / MH) % 4));
        end
      end
    end
  endtask

  task automatic test_sole_hold();
    step(4'b0000, 1'b1);
    a2 = 8'h5C;
    for (int k = 0; k < 10; k++) begin
      step(4'b0100, 1'b0);
      n_vec++; if (gnt !== 4'b0100 || sel !== 2'd2) begin n_err++; $display("FAIL sole_hold cyc %0d: got %b/%0d expected 0100/2", k, gnt, sel); end
    end
    // Saturated owner must yield on the very next edge once someone else asks.
    step(4'b0101, 1'b0);
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL sat_handoff: got %b expected 0001", gnt); end
  endtask

  task automatic test_drop();
    step(4'b0000, 1'b1);
    a3 = 8'hA3;
    step(4'b0010, 1'b0);
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL drop_setup: got %b expected 0010", gnt); end
    step(4'b1001, 1'b0);
    n_vec++; if (gnt !== 4'b1000 || sel !== 2'd3) begin n_err++; $display("FAIL drop_next: got %b/%0d expected 1000/3", gnt, sel); end
    step(4'b0000, 1'b0);
    n_vec++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: got %b/%b expected 0000/0", gnt, busy); end
    n_vec++; if (sel !== 2'd3) begin n_err++; $display("FAIL idle_sel_hold: got %0d expected 3", sel); end
    step(4'b0000, 1'b0);
    n_vec++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL idle_fvalid: got %b expected 0", f_valid); end
    n_vec++; if (f !== 8'hA3) begin n_err++; $display("FAIL idle_f_hold: got %h expected a3", f); end
  endtask

  task automatic test_reset_mid();
    a0 = 8'h21; a1 = 8'h22; a2 = 8'h23; a3 = 8'h24;
    for (int k = 0; k < 6; k++) step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    n_vec++;
    if (gnt !== 4'b0000 || sel !== 2'b00 || f !== '0 || f_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got gnt=%b sel=%b f=%h fv=%b busy=%b expected all zero", gnt, sel, f, f_valid, busy);
    end
    step(4'b1111, 1'b0);
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL post_reset_first: got %b expected 0001", gnt); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] flip;
    logic       rs;
    int         wait_c [4];
    int         max_wait;
    r = 4'b0000;
    max_wait = 0;
    for (int i = 0; i < 4; i++) wait_c[i] = 0;
    step(4'b0000, 1'b1);
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(0, 3) == 0);
      r  = r ^ flip;
      rs = ($urandom_range(0, 255) == 0);
      a0 = W'($urandom); a1 = W'($urandom); a2 = W'($urandom); a3 = W'($urandom);
      step(r, rs);
      n_vec++; if (gnt !== m_gnt()) begin n_err++; $display("FAIL rand_gnt cyc %0d: got %b expected %b", k, gnt, m_gnt()); end
      n_vec++; if (sel !== 2'(m_sel)) begin n_err++; $display("FAIL rand_sel cyc %0d: got %0d expected %0d", k, sel, m_sel); end
      n_vec++; if (f !== m_f || f_valid !== m_fv) begin n_err++; $display("FAIL rand_f cyc %0d: got %h/%b expected %h/%b", k, f, f_valid, m_f, m_fv); end
      n_vec++; if (busy !== (m_owner >= 0)) begin n_err++; $display("FAIL rand_busy cyc %0d: got %b", k, busy); end
      n_vec++; if (!$onehot0(gnt) || (gnt != 4'b0000 && gnt[sel] !== 1'b1)) begin n_err++; $display("FAIL rand_onehot cyc %0d: gnt=%b sel=%0d", k, gnt, sel); end
      for (int i = 0; i < 4; i++) begin
        if (!rs && r[i] && !gnt[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
    end
    n_vec++; if (max_wait > 3 * MH) begin n_err++; $display("FAIL starvation: got wait %0d expected <= %0d", max_wait, 3 * MH); end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    test_reset();
    test_single();
    test_all_req();
    test_sole_hold();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
